uart_tx_pin: RTL and testbench

Serial transmitter that drives an external UART TX pin from internal logic. It is the outbound counterpart of the input-pin synchronizer path that feeds the UART receiver. It accepts one byte per valid/ready handshake and emits a standard 8N1 frame at a parameterized bit period. The pin is driven from a flop only, so no combinational glitch reaches the package boundary.

---
 rtl/uart_tx_pin_pkg.sv | 30 +++
 rtl/uart_tx_pin_bit_timer.sv | 41 ++++
 rtl/uart_tx_pin.sv | 123 ++++++++++++
 tb/tb_uart_tx_pin.sv | 108 ++++++++++
 4 files changed

// File: rtl/uart_tx_pin_pkg.sv
// Shared UART definitions: line states, frame constants and the
// default bit period. Used by both the transmitter and the receiver.
package uart_tx_pin_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  localparam int   UART_DATA_BITS       = 8;
  localparam logic START_BIT_VAL        = 1'b0;
  localparam logic STOP_BIT_VAL         = 1'b1;
  localparam int   DEFAULT_CLKS_PER_BIT = 434;

  // Line level driven while the framer sits in a given state.
  function automatic logic line_level(input uart_state_e st, input logic data_bit);
    logic lvl;
    case (st)
      ST_IDLE:  lvl = STOP_BIT_VAL;
      ST_START: lvl = START_BIT_VAL;
      ST_DATA:  lvl = data_bit;
      ST_STOP:  lvl = STOP_BIT_VAL;
      default:  lvl = STOP_BIT_VAL;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/uart_tx_pin_bit_timer.sv
// Bit-time counter shared by the UART transmitter and receiver.
// Counts one bit period (up from 0 or down to 0) and flags its last
// cycle; the count restarts automatically after the terminal cycle.
module bit_timer
  import uart_tx_pin_pkg::*;
#(
  parameter int   CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter logic COUNT_DOWN   = 1'b0,
  localparam int  CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  output logic o_terminal
);

  localparam logic [CNT_W-1:0] LAST_VAL  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] ZERO_VAL  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] START_VAL = COUNT_DOWN ? LAST_VAL : ZERO_VAL;
  localparam logic [CNT_W-1:0] TERM_VAL  = COUNT_DOWN ? ZERO_VAL : LAST_VAL;

  logic [CNT_W-1:0] r_count;
  logic             w_terminal;

  assign w_terminal = (r_count == TERM_VAL);
  assign o_terminal = w_terminal;

  // Advance the bit-period count; restart on clear or after the terminal cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= START_VAL;
    end else if (i_clear || w_terminal) begin
      r_count <= START_VAL;
    end else if (COUNT_DOWN) begin
      r_count <= r_count - CNT_W'(1);
    end else begin
      r_count <= r_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_pin.sv
// 8N1 UART transmitter driving the external TX pin from a flop.
// One byte per valid/ready handshake; back-to-back frames have no gap.
module uart_tx_pin
  import uart_tx_pin_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] txData,
  input  logic       txValid,
  output logic       txReady,
  output logic       txPin,
  output logic       busy
);

  localparam int                IDX_W    = $clog2(UART_DATA_BITS);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(UART_DATA_BITS - 1);

  uart_state_e                r_state;
  uart_state_e                w_state_next;
  logic [UART_DATA_BITS-1:0]  r_shift;
  logic [UART_DATA_BITS-1:0]  w_shift_next;
  logic [IDX_W-1:0]           r_bit_idx;
  logic [IDX_W-1:0]           w_idx_next;
  logic                       r_tx_pin;
  logic                       w_tx_pin_next;
  logic                       w_terminal;
  logic                       w_timer_clear;
  logic                       w_ready;
  logic                       w_accept;

  // Hold the timer at its start value while idle so an accepted byte
  // gets a full start-bit period.
  assign w_timer_clear = (r_state == ST_IDLE);

  bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .COUNT_DOWN   (1'b0)
  ) u_bit_timer (
    .clk        (clk),
    .rst        (rst),
    .i_clear    (w_timer_clear),
    .o_terminal (w_terminal)
  );

  // Ready in idle, or in the final stop-bit cycle so the next frame follows without a gap.
  assign w_ready  = (r_state == ST_IDLE) || ((r_state == ST_STOP) && w_terminal);
  assign w_accept = txValid && w_ready;

  assign txReady = w_ready;
  assign txPin   = r_tx_pin;
  assign busy    = (r_state != ST_IDLE);

  // Next-state, shift register and bit index; pin level follows the next state.
  always_comb begin
    w_state_next = r_state;
    w_shift_next = r_shift;
    w_idx_next   = r_bit_idx;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_next = ST_START;
          w_shift_next = txData;
          w_idx_next   = {IDX_W{1'b0}};
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_START: begin
        if (w_terminal) begin
          w_state_next = ST_DATA;
        end else begin
          w_state_next = ST_START;
        end
      end
      ST_DATA: begin
        if (w_terminal) begin
          w_shift_next = {1'b0, r_shift[UART_DATA_BITS-1:1]};
          if (r_bit_idx == LAST_IDX) begin
            w_state_next = ST_STOP;
            w_idx_next   = {IDX_W{1'b0}};
          end else begin
            w_idx_next   = r_bit_idx + IDX_W'(1);
          end
        end else begin
          w_state_next = ST_DATA;
        end
      end
      ST_STOP: begin
        if (w_terminal && w_accept) begin
          w_state_next = ST_START;
          w_shift_next = txData;
          w_idx_next   = {IDX_W{1'b0}};
        end else if (w_terminal) begin
          w_state_next = ST_IDLE;
        end else begin
          w_state_next = ST_STOP;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
    w_tx_pin_next = line_level(w_state_next, w_shift_next[0]);
  end

  // State, data and pin registers; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_shift   <= {UART_DATA_BITS{1'b0}};
      r_bit_idx <= {IDX_W{1'b0}};
      r_tx_pin  <= STOP_BIT_VAL;
    end else begin
      r_state   <= w_state_next;
      r_shift   <= w_shift_next;
      r_bit_idx <= w_idx_next;
      r_tx_pin  <= w_tx_pin_next;
    end
  end

endmodule

// File: tb/tb_uart_tx_pin.sv
// Scoreboard bench for uart_tx_pin at 4 clocks per bit. Each accepted
// byte pushes its full per-cycle {pin, ready, busy} sequence; every
// cycle pops one entry (idle values when empty) and compares.
module tb_uart_tx_pin;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] txData;
  logic       txValid;
  logic       txReady;
  logic       txPin;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  logic [2:0] exp_q[$];

  uart_tx_pin #(.CLKS_PER_BIT(CPB)) dut (
    .clk     (clk),
    .rst     (rst),
    .txData  (txData),
    .txValid (txValid),
    .txReady (txReady),
    .txPin   (txPin),
    .busy    (busy)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, act, exp);
    end
  endtask

  // Expected per-cycle {pin, ready, busy} for one frame.
  task automatic push_frame(input logic [7:0] b);
    for (int i = 0; i < CPB; i++) exp_q.push_back(3'b001);
    for (int k = 0; k < 8; k++)
      for (int i = 0; i < CPB; i++) exp_q.push_back({b[k], 1'b0, 1'b1});
    for (int i = 0; i < CPB - 1; i++) exp_q.push_back(3'b101);
    exp_q.push_back(3'b111);
  endtask

  // One cycle: check outputs, then drive inputs for this cycle and update the model.
  task automatic step(input logic v, input logic [7:0] d, input logic r);
    logic [2:0] e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else                  e = 3'b110;
    check_val("txPin",   32'(txPin),   32'(e[2]));
    check_val("txReady", 32'(txReady), 32'(e[1]));
    check_val("busy",    32'(busy),    32'(e[0]));
    txValid = v;
    txData  = d;
    rst     = r;
    if (r) exp_q.delete();
    else if (v && e[1]) push_frame(d);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    // Reset held two cycles with a pending request: no frame may start.
    rst     = 1'b1;
    txValid = 1'b1;
    txData  = 8'h77;
    step(1'b1, 8'h77, 1'b1);
    idle_cycles(3);

    // Single byte 0xA5; txData changes to 0x3C after acceptance.
    step(1'b1, 8'hA5, 1'b0);
    step(1'b0, 8'hA5, 1'b0);
    for (int i = 0; i < 44; i++) step(1'b0, 8'h3C, 1'b0);

    // Back-to-back 0x00 then 0xFF with txValid held.
    step(1'b1, 8'h00, 1'b0);
    for (int i = 0; i < 10 * CPB; i++) step(1'b1, 8'hFF, 1'b0);
    idle_cycles(10 * CPB + 5);

    // Ignored one-cycle request at cycle 12 of a frame.
    step(1'b1, 8'hC3, 1'b0);
    for (int i = 1; i < 12; i++) step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h11, 1'b0);
    idle_cycles(10 * CPB + 5);

    // Reset during data bit 3, then a clean frame of 0x5A.
    step(1'b1, 8'h96, 1'b0);
    for (int i = 1; i < 18; i++) step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h5A, 1'b0);
    idle_cycles(10 * CPB + 5);

    check_val("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
